// File: rtl/csr_gpio_unit.sv
// csr_gpio_unit: GPIO CSR responder for the 3-stage RISC-V core.
// Serves CSRRW accesses from EX with one-cycle registered read data for WB,
// owns the io2 display register, debounces the board switches for io0 and
// keeps a free-running cycle counter.
module csr_gpio_unit #(
    parameter int SW_WIDTH        = 18,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                csr_en_EX,
    input  logic [11:0]         csr_addr_EX,
    input  logic                gpio_we_EX,
    input  logic [31:0]         csr_wdata_EX,
    input  logic [SW_WIDTH-1:0] SW,
    output logic [31:0]         csr_rdata_WB,
    output logic                csr_hit_WB,
    output logic [31:0]         hex_out,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX4,
    output logic [6:0]          HEX5,
    output logic [6:0]          HEX6,
    output logic [6:0]          HEX7
);

    // CSR address map
    localparam logic [11:0] ADDR_IO0   = 12'hF00;
    localparam logic [11:0] ADDR_IO2   = 12'hF02;
    localparam logic [11:0] ADDR_CYCLE = 12'hC00;

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1
    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Active-low glyph for digit '0', the display state out of reset
    localparam logic [6:0] GLYPH_ZERO = 7'b1000000;

    // Active-low 7-segment glyph for one hex nibble (segment g is bit 6)
    function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Switch synchronizer and debounce state
    logic [SW_WIDTH-1:0] sync1_q,     sync1_d;
    logic [SW_WIDTH-1:0] sw_sync_q,   sw_sync_d;
    logic [SW_WIDTH-1:0] sw_cand_q,   sw_cand_d;
    logic [SW_WIDTH-1:0] sw_stable_q, sw_stable_d;
    logic [CNT_W-1:0]    deb_cnt_q,   deb_cnt_d;

    // Free-running cycle counter
    logic [31:0] cycle_q, cycle_d;

    // CSR side: io2 register and WB-stage read result
    logic [31:0] hex_q,       hex_d;
    logic [31:0] csr_rdata_q, csr_rdata_d;
    logic        csr_hit_q,   csr_hit_d;
    logic [31:0] rd_sel;
    logic        rd_hit;
    logic        io2_write;

    // Registered segment drives, one 7-bit glyph per digit
    logic [7:0][6:0] seg_q, seg_d;

    // Two-flop synchronizer followed by a stability counter on the switch word
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        sync1_d     = SW;
        sw_sync_d   = sync1_q;
        sw_cand_d   = sw_cand_q;
        sw_stable_d = sw_stable_q;
        deb_cnt_d   = deb_cnt_q;
        if (sw_sync_q != sw_cand_q) begin
            // Any change, including a bounce, restarts the stability window
            sw_cand_d = sw_sync_q;
            deb_cnt_d = '0;
        end else if (deb_cnt_q == CNT_LAST) begin
            // Window complete: accept the candidate and hold the counter
            sw_stable_d = sw_cand_q;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // Cycle counter wraps naturally at 32 bits
    always_comb begin
        cycle_d = cycle_q + 32'd1;
    end

    // CSR read decode, WB capture and io2 write
    always_comb begin
        rd_sel = '0;
        rd_hit = 1'b0;
        case (csr_addr_EX)
            ADDR_IO0: begin
                rd_sel = 32'(sw_stable_q);
                rd_hit = 1'b1;
            end
            ADDR_IO2: begin
                rd_sel = hex_q;
                rd_hit = 1'b1;
            end
            ADDR_CYCLE: begin
                rd_sel = cycle_q;
                rd_hit = 1'b1;
            end
            default: ;
        endcase

        // Read data holds between accesses; hit is a single-cycle flag
        csr_rdata_d = csr_rdata_q;
        csr_hit_d   = 1'b0;
        if (csr_en_EX) begin
            csr_rdata_d = rd_sel;
            csr_hit_d   = rd_hit;
        end

        // CSRRW reads the old io2 value above while the new one lands here
        io2_write = csr_en_EX && gpio_we_EX && (csr_addr_EX == ADDR_IO2);
        hex_d     = io2_write ? csr_wdata_EX : hex_q;
    end

    // Glyph lookup for each io2 nibble
    always_comb begin
        seg_d = seg_q;
        for (int i = 0; i < 8; i++) begin
            seg_d[i] = seg_glyph(hex_q[4*i +: 4]);
        end
    end

    // Switch path and cycle counter registers
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values and the pipeline order is simulation-safe.
        if (rst) begin
            sync1_q     <= '0;
            sw_sync_q   <= '0;
            sw_cand_q   <= '0;
            sw_stable_q <= '0;
            deb_cnt_q   <= '0;
            cycle_q     <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sw_sync_q   <= sw_sync_d;
            sw_cand_q   <= sw_cand_d;
            sw_stable_q <= sw_stable_d;
            deb_cnt_q   <= deb_cnt_d;
            cycle_q     <= cycle_d;
        end
    end

    // CSR-side registers: io2, WB read result and segment drives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_q       <= '0;
            csr_rdata_q <= '0;
            csr_hit_q   <= 1'b0;
            seg_q       <= {8{GLYPH_ZERO}};
        end else begin
            hex_q       <= hex_d;
            csr_rdata_q <= csr_rdata_d;
            csr_hit_q   <= csr_hit_d;
            seg_q       <= seg_d;
        end
    end

    assign csr_rdata_WB = csr_rdata_q;
    assign csr_hit_WB   = csr_hit_q;
    assign hex_out      = hex_q;
    assign HEX0         = seg_q[0];
    assign HEX1         = seg_q[1];
    assign HEX2         = seg_q[2];
    assign HEX3         = seg_q[3];
    assign HEX4         = seg_q[4];
    assign HEX5         = seg_q[5];
    assign HEX6         = seg_q[6];
    assign HEX7         = seg_q[7];

endmodule

// File: tb/tb_csr_gpio_unit.sv
// tb_csr_gpio_unit: directed bench for csr_gpio_unit with a read-data scoreboard.
module tb_csr_gpio_unit;

    localparam int SW_WIDTH        = 18;
    localparam int DEBOUNCE_CYCLES = 4;
    // Edge index (counted from the SW step) whose read first sees the new value
    localparam int FIRST_NEW_READ  = 2 + DEBOUNCE_CYCLES + 1 + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                csr_en_EX;
    logic [11:0]         csr_addr_EX;
    logic                gpio_we_EX;
    logic [31:0]         csr_wdata_EX;
    logic [SW_WIDTH-1:0] SW;
    logic [31:0]         csr_rdata_WB;
    logic                csr_hit_WB;
    logic [31:0]         hex_out;
    logic [6:0]          HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

    csr_gpio_unit #(
        .SW_WIDTH        (SW_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .csr_en_EX    (csr_en_EX),
        .csr_addr_EX  (csr_addr_EX),
        .gpio_we_EX   (gpio_we_EX),
        .csr_wdata_EX (csr_wdata_EX),
        .SW           (SW),
        .csr_rdata_WB (csr_rdata_WB),
        .csr_hit_WB   (csr_hit_WB),
        .hex_out      (hex_out),
        .HEX0         (HEX0),
        .HEX1         (HEX1),
        .HEX2         (HEX2),
        .HEX3         (HEX3),
        .HEX4         (HEX4),
        .HEX5         (HEX5),
        .HEX6         (HEX6),
        .HEX7         (HEX7)
    );

    always #5 clk = ~clk;

    // Scoreboard entry: expected WB result of one access cycle
    typedef struct packed {
        logic [31:0] rdata;
        logic        hit;
        logic        chk_data;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0]         m_hex     = '0;
    logic [31:0]         m_last    = '0;
    logic                m_last_ok = 1'b1;
    logic [SW_WIDTH-1:0] m_sw      = '0;

    // Active-low glyph table 0..F
    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [31:0] c1, c2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare all eight digits against the glyphs of a 32-bit value
    task automatic check_hex(input string tag, input logic [31:0] val);
        logic [6:0] obs [8];
        obs[0] = HEX0; obs[1] = HEX1; obs[2] = HEX2; obs[3] = HEX3;
        obs[4] = HEX4; obs[5] = HEX5; obs[6] = HEX6; obs[7] = HEX7;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_HEX%0d", tag, i), 32'(obs[i]), 32'(glyph[val[4*i +: 4]]));
        end
    endtask

    // One clock of CSR traffic: predict, drive, then compare after the edge
    task automatic access(input logic en, input logic [11:0] addr, input logic we,
                          input logic [31:0] wdata, input string tag);
        exp_t  e;
        string t;
        e.hit      = 1'b0;
        e.rdata    = m_last;
        e.chk_data = m_last_ok;
        if (en) begin
            e.rdata    = '0;
            e.chk_data = 1'b1;
            case (addr)
                12'hF00: begin e.rdata = 32'(m_sw); e.hit = 1'b1; end
                12'hF02: begin e.rdata = m_hex;     e.hit = 1'b1; end
                12'hC00: begin e.hit = 1'b1; e.chk_data = 1'b0; end
                default: ;
            endcase
        end
        m_last    = e.rdata;
        m_last_ok = e.chk_data;
        if (en && we && addr == 12'hF02) m_hex = wdata;
        sb_q.push_back(e);
        tag_q.push_back(tag);

        csr_en_EX    = en;
        csr_addr_EX  = addr;
        gpio_we_EX   = we;
        csr_wdata_EX = wdata;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_hit"}, 32'(csr_hit_WB), 32'(e.hit));
        if (e.chk_data) check({t, "_rdata"}, csr_rdata_WB, e.rdata);
        check({t, "_hexout"}, hex_out, m_hex);
        csr_en_EX  = 1'b0;
        gpio_we_EX = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        csr_en_EX    = 1'b0;
        csr_addr_EX  = '0;
        gpio_we_EX   = 1'b0;
        csr_wdata_EX = '0;
        SW           = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", csr_rdata_WB, 32'h0);
        check("rst_hit", 32'(csr_hit_WB), 32'h0);
        check("rst_hexout", hex_out, 32'h0);
        check_hex("rst", 32'h0);
        rst = 1'b0;

        // CSRRW write of io2, then the display one cycle later
        access(1'b1, 12'hF02, 1'b1, 32'h1234ABCD, "wr_io2");
        check("hex_lag_HEX0", 32'(HEX0), 32'(7'b1000000));
        access(1'b0, 12'h000, 1'b0, 32'h0, "idle_after_wr");
        check_hex("disp", 32'h1234ABCD);

        // Back-to-back CSRRW: second read returns the first write's data
        access(1'b1, 12'hF02, 1'b1, 32'h0000000A, "b2b_first");
        access(1'b1, 12'hF02, 1'b1, 32'h0000000B, "b2b_second");
        access(1'b0, 12'h000, 1'b0, 32'h0, "idle_after_b2b");
        check_hex("disp_b", 32'h0000000B);

        // Unmapped and ignored writes
        access(1'b1, 12'h123, 1'b1, 32'h0000FFFF, "unmapped");
        access(1'b0, 12'hF02, 1'b1, 32'h0000FFFF, "we_no_en");
        access(1'b1, 12'hF00, 1'b1, 32'h0000FFFF, "io0_ro");
        access(1'b1, 12'hF02, 1'b0, 32'h0, "rd_io2");

        // Clean switch step: new value readable only from FIRST_NEW_READ on
        SW = 18'h00015;
        for (int k = 1; k <= 10; k++) begin
            m_sw = (k >= FIRST_NEW_READ) ? 18'h00015 : 18'h0;
            access(1'b1, 12'hF00, 1'b0, 32'h0, $sformatf("deb_step_%0d", k));
        end

        // Bit 0 bouncing every 2 cycles never settles long enough
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) SW[0] = ~SW[0];
            access(1'b1, 12'hF00, 1'b0, 32'h0, $sformatf("bounce_%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            access(1'b1, 12'hF00, 1'b0, 32'h0, $sformatf("post_bounce_%0d", i));
        end

        // Reset mid-run and mid-debounce with all switches on
        SW = 18'h3FFFF;
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 12'h000, 1'b0, 32'h0, $sformatf("pre_rst_%0d", i));
        end
        #2;
        rst = 1'b1;
        #1;
        m_hex     = '0;
        m_last    = '0;
        m_last_ok = 1'b1;
        m_sw      = '0;
        check("midrst_rdata", csr_rdata_WB, 32'h0);
        check("midrst_hit", 32'(csr_hit_WB), 32'h0);
        check("midrst_hexout", hex_out, 32'h0);
        check_hex("midrst", 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            m_sw = (k >= FIRST_NEW_READ) ? 18'h3FFFF : 18'h0;
            access(1'b1, 12'hF00, 1'b0, 32'h0, $sformatf("postrst_io0_%0d", k));
        end

        // Cycle counter: reads 10 edges apart differ by 10
        access(1'b1, 12'hC00, 1'b0, 32'h0, "cyc_a");
        c1 = csr_rdata_WB;
        for (int i = 0; i < 9; i++) begin
            access(1'b0, 12'h000, 1'b0, 32'h0, $sformatf("cyc_gap_%0d", i));
        end
        access(1'b1, 12'hC00, 1'b0, 32'h0, "cyc_b");
        c2 = csr_rdata_WB;
        check("cycle_delta", c2 - c1, 32'd10);

        // Counter wrap
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        access(1'b1, 12'hC00, 1'b0, 32'h0, "cyc_max");
        check("cycle_max_val", csr_rdata_WB, 32'hFFFF_FFFF);
        access(1'b1, 12'hC00, 1'b0, 32'h0, "cyc_wrap");
        check("cycle_wrap_val", csr_rdata_WB, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
